// File: rtl/regfile_multi_if.sv
// ============================================================================
//  Module   : regfile_multi_if
//  Desc     : Lookup / rename / commit / rollback bundle for regfile_multi.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_multi_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_IDX_W = 4,
  parameter int RD_PORTS  = 2,
  parameter int CMT_PORTS = 2
);
  logic                          rdy;
  logic                          rollback;
  logic [RD_PORTS*REG_IDX_W-1:0] rd_idx;
  logic [RD_PORTS-1:0]           rd_busy;
  logic [RD_PORTS*XLEN-1:0]      rd_data;
  logic [RD_PORTS*ROB_IDX_W-1:0] rd_tag;
  logic                          ren_valid;
  logic [REG_IDX_W-1:0]          ren_rd;
  logic [ROB_IDX_W-1:0]          ren_tag;
  logic [CMT_PORTS-1:0]           cmt_valid;
  logic [CMT_PORTS*REG_IDX_W-1:0] cmt_rd;
  logic [CMT_PORTS*ROB_IDX_W-1:0] cmt_tag;
  logic [CMT_PORTS*XLEN-1:0]      cmt_data;
  logic [REG_IDX_W:0]             busy_count;

  modport master (
    output rdy, rollback, rd_idx, ren_valid, ren_rd, ren_tag,
           cmt_valid, cmt_rd, cmt_tag, cmt_data,
    input  rd_busy, rd_data, rd_tag, busy_count
  );

  modport slave (
    input  rdy, rollback, rd_idx, ren_valid, ren_rd, ren_tag,
           cmt_valid, cmt_rd, cmt_tag, cmt_data,
    output rd_busy, rd_data, rd_tag, busy_count
  );
endinterface

`default_nettype wire

// File: rtl/regfile_multi.sv
// ============================================================================
//  Module   : regfile_multi
//  Desc     : Architectural register file with ROB rename tags, commit bypass
//             and full rollback.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multi #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_IDX_W = 4,
  parameter int RD_PORTS  = 2,
  parameter int CMT_PORTS = 2
) (
  input  wire             clk,
  input  wire             rst,
  regfile_multi_if.slave  bus
);

  localparam int c_REG_NUM = 1 << REG_IDX_W;
  localparam int c_CNT_W   = REG_IDX_W + 1;

  logic [XLEN-1:0]      r_data [c_REG_NUM];
  logic [ROB_IDX_W-1:0] r_tag  [c_REG_NUM];
  logic [c_REG_NUM-1:0] r_busy;
  logic [c_CNT_W-1:0]   r_busy_count;

  logic [XLEN-1:0]      w_data_nxt [c_REG_NUM];
  logic [ROB_IDX_W-1:0] w_tag_nxt  [c_REG_NUM];
  logic [c_REG_NUM-1:0] w_busy_nxt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;

  // Operand lookup; the bypass scans ports in order so the youngest match wins.
  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd_port
    logic [REG_IDX_W-1:0] w_idx;
    logic                 w_busy;
    logic [XLEN-1:0]      w_data;
    logic [ROB_IDX_W-1:0] w_tag;

    assign w_idx = bus.rd_idx[i*REG_IDX_W +: REG_IDX_W];

    always_comb begin
      w_busy = 1'b0;
      w_data = '0;
      w_tag  = '0;
      if (w_idx != '0) begin
        w_busy = r_busy[w_idx];
        w_data = r_data[w_idx];
        w_tag  = r_tag[w_idx];
        for (int c = 0; c < CMT_PORTS; c++) begin
          if (r_busy[w_idx] && bus.cmt_valid[c] &&
              bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W] == w_idx &&
              bus.cmt_tag[c*ROB_IDX_W +: ROB_IDX_W] == r_tag[w_idx]) begin
            w_busy = 1'b0;
            w_data = bus.cmt_data[c*XLEN +: XLEN];
            w_tag  = '0;
          end
        end
      end
    end

    assign bus.rd_busy[i]                        = w_busy;
    assign bus.rd_data[i*XLEN +: XLEN]           = w_data;
    assign bus.rd_tag[i*ROB_IDX_W +: ROB_IDX_W]  = w_tag;
  end

  // Next state: commit clear < rename < rollback; data writes stand alone.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < c_REG_NUM; r++) begin
      w_data_nxt[r] = r_data[r];
      w_tag_nxt[r]  = r_tag[r];
    end

    for (int c = 0; c < CMT_PORTS; c++) begin
      if (bus.cmt_valid[c] && bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W] != '0) begin
        w_data_nxt[bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W]] = bus.cmt_data[c*XLEN +: XLEN];
        if (r_busy[bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W]] &&
            r_tag[bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W]] ==
              bus.cmt_tag[c*ROB_IDX_W +: ROB_IDX_W]) begin
          w_busy_nxt[bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W]] = 1'b0;
          w_tag_nxt[bus.cmt_rd[c*REG_IDX_W +: REG_IDX_W]]  = '0;
        end
      end
    end

    if (bus.ren_valid && bus.ren_rd != '0) begin
      w_busy_nxt[bus.ren_rd] = 1'b1;
      w_tag_nxt[bus.ren_rd]  = bus.ren_tag;
    end

    if (bus.rollback) begin
      w_busy_nxt = '0;
      for (int r = 0; r < c_REG_NUM; r++) begin
        w_tag_nxt[r] = '0;
      end
    end

    w_busy_nxt[0] = 1'b0;
    w_data_nxt[0] = '0;
    w_tag_nxt[0]  = '0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int r = 0; r < c_REG_NUM; r++) begin
      w_cnt_nxt = w_cnt_nxt + c_CNT_W'(w_busy_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= '0;
      r_busy_count <= '0;
      for (int r = 0; r < c_REG_NUM; r++) begin
        r_data[r] <= '0;
        r_tag[r]  <= '0;
      end
    end else if (bus.rdy) begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_cnt_nxt;
      for (int r = 0; r < c_REG_NUM; r++) begin
        r_data[r] <= w_data_nxt[r];
        r_tag[r]  <= w_tag_nxt[r];
      end
    end
  end

  assign bus.busy_count = r_busy_count;

endmodule

`default_nettype wire

// File: tb/tb_regfile_multi.sv
// ============================================================================
//  Module   : tb_regfile_multi
//  Desc     : Directed self-checking bench for regfile_multi.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_multi;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int TW   = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  regfile_multi_if #(.XLEN(XLEN), .REG_IDX_W(RW), .ROB_IDX_W(TW),
                     .RD_PORTS(2), .CMT_PORTS(2)) bus ();

  regfile_multi #(.XLEN(XLEN), .REG_IDX_W(RW), .ROB_IDX_W(TW),
                  .RD_PORTS(2), .CMT_PORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            b0, b1;
  logic [XLEN-1:0] d0, d1;
  logic [TW-1:0]   t0, t1;
  logic [RW:0]     cnt;
  assign b0  = bus.rd_busy[0];
  assign b1  = bus.rd_busy[1];
  assign d0  = bus.rd_data[0 +: XLEN];
  assign d1  = bus.rd_data[XLEN +: XLEN];
  assign t0  = bus.rd_tag[0 +: TW];
  assign t1  = bus.rd_tag[TW +: TW];
  assign cnt = bus.busy_count;

  task automatic step();
    @(posedge clk);
    #1;
    bus.ren_valid = 1'b0;
    bus.cmt_valid = '0;
    bus.rollback  = 1'b0;
  endtask

  task automatic ren(input int r, input int t);
    bus.ren_valid = 1'b1;
    bus.ren_rd    = RW'(r);
    bus.ren_tag   = TW'(t);
  endtask

  task automatic cmt(input int p, input int r, input int t, input logic [XLEN-1:0] d);
    bus.cmt_valid[p]            = 1'b1;
    bus.cmt_rd[p*RW +: RW]      = RW'(r);
    bus.cmt_tag[p*TW +: TW]     = TW'(t);
    bus.cmt_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic look(input int r0, input int r1);
    bus.rd_idx = {RW'(r1), RW'(r0)};
    #1;
  endtask

  task automatic test_reset();
    ren(5, 1); step();
    cmt(0, 5, 1, 32'h0000_1234); step();
    ren(5, 2); step();
    look(5, 0);
    n_cmp++; if (b0 !== 1'b1 || t0 !== 4'd2 || d0 !== 32'h1234) begin n_err++;
      $display("FAIL pre_reset_x5: busy=%b tag=%0d data=%h want 1/2/00001234", b0, t0, d0); end
    n_cmp++; if (cnt !== 6'd1) begin n_err++;
      $display("FAIL pre_reset_count: got %0d want 1", cnt); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (b0 !== 1'b0 || t0 !== 4'd0 || d0 !== 32'h0) begin n_err++;
      $display("FAIL reset_x5: busy=%b tag=%0d data=%h want 0/0/0", b0, t0, d0); end
    n_cmp++; if (b1 !== 1'b0 || t1 !== 4'd0 || d1 !== 32'h0) begin n_err++;
      $display("FAIL reset_x0: busy=%b tag=%0d data=%h want 0/0/0", b1, t1, d1); end
    n_cmp++; if (cnt !== 6'd0) begin n_err++;
      $display("FAIL reset_count: got %0d want 0", cnt); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_rename_commit();
    ren(3, 7); step();
    look(3, 0);
    n_cmp++; if (b0 !== 1'b1 || t0 !== 4'd7) begin n_err++;
      $display("FAIL ren_x3: busy=%b tag=%0d want 1/7", b0, t0); end
    n_cmp++; if (cnt !== 6'd1) begin n_err++;
      $display("FAIL ren_count: got %0d want 1", cnt); end
    cmt(0, 3, 7, 32'hDEAD_BEEF); #1;
    n_cmp++; if (b0 !== 1'b0 || d0 !== 32'hDEAD_BEEF || t0 !== 4'd0) begin n_err++;
      $display("FAIL bypass_x3: busy=%b data=%h tag=%0d want 0/deadbeef/0", b0, d0, t0); end
    step(); #1;
    n_cmp++; if (b0 !== 1'b0 || d0 !== 32'hDEAD_BEEF || t0 !== 4'd0) begin n_err++;
      $display("FAIL stored_x3: busy=%b data=%h tag=%0d want 0/deadbeef/0", b0, d0, t0); end
    n_cmp++; if (cnt !== 6'd0) begin n_err++;
      $display("FAIL cmt_count: got %0d want 0", cnt); end
  endtask

  task automatic test_stale_commit();
    ren(4, 2); step();
    ren(4, 5); step();
    cmt(0, 4, 2, 32'h11); step();
    look(4, 0);
    n_cmp++; if (b0 !== 1'b1 || t0 !== 4'd5 || d0 !== 32'h11) begin n_err++;
      $display("FAIL stale_x4: busy=%b tag=%0d data=%h want 1/5/11", b0, t0, d0); end
    n_cmp++; if (cnt !== 6'd1) begin n_err++;
      $display("FAIL stale_count: got %0d want 1", cnt); end
    cmt(0, 4, 5, 32'h22); step(); #1;
    n_cmp++; if (b0 !== 1'b0 || d0 !== 32'h22) begin n_err++;
      $display("FAIL fresh_x4: busy=%b data=%h want 0/22", b0, d0); end
  endtask

  task automatic test_dual_commit();
    ren(6, 3); step();
    cmt(0, 6, 1, 32'hAA);
    cmt(1, 6, 3, 32'hBB);
    step();
    look(6, 0);
    n_cmp++; if (b0 !== 1'b0 || d0 !== 32'hBB || t0 !== 4'd0) begin n_err++;
      $display("FAIL dual_x6: busy=%b data=%h tag=%0d want 0/bb/0", b0, d0, t0); end
    n_cmp++; if (cnt !== 6'd0) begin n_err++;
      $display("FAIL dual_count: got %0d want 0", cnt); end
  endtask

  task automatic test_rename_vs_commit();
    ren(8, 4); step();
    cmt(0, 8, 4, 32'h55);
    ren(8, 9);
    step();
    look(8, 0);
    n_cmp++; if (b0 !== 1'b1 || t0 !== 4'd9 || d0 !== 32'h55) begin n_err++;
      $display("FAIL rvc_x8: busy=%b tag=%0d data=%h want 1/9/55", b0, t0, d0); end
    n_cmp++; if (cnt !== 6'd1) begin n_err++;
      $display("FAIL rvc_count: got %0d want 1", cnt); end
  endtask

  task automatic test_rollback();
    ren(1, 1); step();
    ren(2, 2); step();
    ren(9, 3); step();
    n_cmp++; if (cnt !== 6'd4) begin n_err++;
      $display("FAIL pre_rb_count: got %0d want 4", cnt); end
    bus.rollback = 1'b1;
    ren(10, 6);
    cmt(0, 9, 11, 32'h77);
    step();
    look(9, 10);
    n_cmp++; if (b0 !== 1'b0 || t0 !== 4'd0 || d0 !== 32'h77) begin n_err++;
      $display("FAIL rb_x9: busy=%b tag=%0d data=%h want 0/0/77", b0, t0, d0); end
    n_cmp++; if (b1 !== 1'b0 || t1 !== 4'd0) begin n_err++;
      $display("FAIL rb_x10: busy=%b tag=%0d want 0/0", b1, t1); end
    look(1, 8);
    n_cmp++; if (b0 !== 1'b0 || t0 !== 4'd0 || b1 !== 1'b0 || t1 !== 4'd0) begin n_err++;
      $display("FAIL rb_x1_x8: busy=%b/%b tag=%0d/%0d want 0/0 0/0", b0, b1, t0, t1); end
    n_cmp++; if (cnt !== 6'd0) begin n_err++;
      $display("FAIL rb_count: got %0d want 0", cnt); end
  endtask

  task automatic test_rdy_hold();
    ren(12, 5); step();
    bus.rdy      = 1'b0;
    bus.rollback = 1'b1;
    ren(13, 7);
    cmt(0, 12, 5, 32'h99);
    look(12, 13);
    n_cmp++; if (b0 !== 1'b0 || d0 !== 32'h99) begin n_err++;
      $display("FAIL hold_bypass_x12: busy=%b data=%h want 0/99", b0, d0); end
    step(); #1;
    n_cmp++; if (b0 !== 1'b1 || t0 !== 4'd5 || d0 !== 32'h0) begin n_err++;
      $display("FAIL hold_x12: busy=%b tag=%0d data=%h want 1/5/0", b0, t0, d0); end
    n_cmp++; if (b1 !== 1'b0) begin n_err++;
      $display("FAIL hold_x13: busy=%b want 0", b1); end
    n_cmp++; if (cnt !== 6'd1) begin n_err++;
      $display("FAIL hold_count: got %0d want 1", cnt); end
    bus.rdy = 1'b1;
  endtask

  task automatic test_x0();
    ren(0, 3);
    cmt(0, 0, 0, 32'hFFFF_FFFF);
    step();
    look(0, 12);
    n_cmp++; if (b0 !== 1'b0 || d0 !== 32'h0 || t0 !== 4'd0) begin n_err++;
      $display("FAIL x0_hardwired: busy=%b data=%h tag=%0d want 0/0/0", b0, d0, t0); end
    n_cmp++; if (cnt !== 6'd1 || b1 !== 1'b1) begin n_err++;
      $display("FAIL x0_count: count=%0d x12busy=%b want 1/1", cnt, b1); end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.rdy       = 1'b1;
    bus.rollback  = 1'b0;
    bus.rd_idx    = '0;
    bus.ren_valid = 1'b0;
    bus.ren_rd    = '0;
    bus.ren_tag   = '0;
    bus.cmt_valid = '0;
    bus.cmt_rd    = '0;
    bus.cmt_tag   = '0;
    bus.cmt_data  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_dual_commit();
    test_rename_vs_commit();
    test_rollback();
    test_rdy_hold();
    test_x0();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
